// File: rtl/conf_int_mul_rr_sched_if.sv
// Request/response bundle between requesting kernels and the shared-multiplier scheduler.
// The scheduler binds the slave modport; requesters/consumer bind master.
interface conf_int_mul_rr_sched_if #(
   parameter int unsigned NUM_REQ            = 4,
   parameter int unsigned DATA_PATH_BITWIDTH = 16,
   parameter int unsigned ID_W               = 2
);
   logic [NUM_REQ-1:0]                    req_valid;
   logic [NUM_REQ-1:0]                    req_ready;
   logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_b;
   logic                                  rsp_valid;
   logic                                  rsp_ready;
   logic [ID_W-1:0]                       rsp_id;
   logic [2*DATA_PATH_BITWIDTH-1:0]       rsp_d;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_d
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_d
   );
endinterface

// File: rtl/conf_int_mul_rr_sched.sv
// Round-robin time-sharing of one unsigned multiplier among NUM_REQ requesters,
// with a MUL_LATENCY-deep tagged result pipeline that stalls as a whole on backpressure.
module conf_int_mul_rr_sched #(
   parameter int unsigned OP_BITWIDTH        = 16,
   parameter int unsigned DATA_PATH_BITWIDTH = 16,
   parameter int unsigned NUM_REQ            = 4,
   parameter int unsigned ID_W               = 2,
   parameter int unsigned MUL_LATENCY        = 2
) (
   input logic                    clk,
   input logic                    rst,
   conf_int_mul_rr_sched_if.slave bus
);
   localparam int unsigned DW = DATA_PATH_BITWIDTH;
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned L  = MUL_LATENCY;

   logic [ID_W-1:0] ptr;
   logic [L-1:0]    stg_v;
   logic [ID_W-1:0] stg_id [L];
   logic [PW-1:0]   stg_d  [L];

   logic            stall;
   logic            gnt_ok;
   logic            accept;
   logic [ID_W-1:0] gnt_idx;
   logic [DW-1:0]   a_sel;
   logic [DW-1:0]   b_sel;
   logic [DW-1:0]   op_mask;
   logic [PW-1:0]   prod;

   assign stall = stg_v[L-1] & ~bus.rsp_ready;

   // Search indices at/above ptr first, then the wrapped indices below ptr.
   always_comb begin
      gnt_ok  = 1'b0;
      gnt_idx = '0;
      a_sel   = '0;
      b_sel   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_ok && bus.req_valid[i] && i >= 32'(ptr)) begin
            gnt_ok  = 1'b1;
            gnt_idx = ID_W'(i);
            a_sel   = bus.req_a[i*DW +: DW];
            b_sel   = bus.req_b[i*DW +: DW];
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_ok && bus.req_valid[i] && i < 32'(ptr)) begin
            gnt_ok  = 1'b1;
            gnt_idx = ID_W'(i);
            a_sel   = bus.req_a[i*DW +: DW];
            b_sel   = bus.req_b[i*DW +: DW];
         end
      end
   end

   always_comb begin
      op_mask = '0;
      for (int unsigned j = 0; j < DW; j++) begin
         op_mask[j] = (j < OP_BITWIDTH);
      end
   end

   assign prod   = PW'(a_sel & op_mask) * PW'(b_sel & op_mask);
   assign accept = gnt_ok & ~stall;

   always_comb begin
      bus.req_ready = '0;
      if (accept && rst) begin
         bus.req_ready[gnt_idx] = 1'b1;
      end
   end

   // Bubbles carry zero id/data because the grant mux defaults to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr   <= '0;
         stg_v <= '0;
         for (int unsigned k = 0; k < L; k++) begin
            stg_id[k] <= '0;
            stg_d[k]  <= '0;
         end
      end else if (!stall) begin
         stg_v[0]  <= accept;
         stg_id[0] <= gnt_idx;
         stg_d[0]  <= prod;
         for (int unsigned k = 1; k < L; k++) begin
            stg_v[k]  <= stg_v[k-1];
            stg_id[k] <= stg_id[k-1];
            stg_d[k]  <= stg_d[k-1];
         end
         if (accept) begin
            if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
               ptr <= '0;
            end else begin
               ptr <= gnt_idx + 1'b1;
            end
         end
      end
   end

   assign bus.rsp_valid = stg_v[L-1];
   assign bus.rsp_id    = stg_id[L-1];
   assign bus.rsp_d     = stg_d[L-1];
endmodule
